// File: rtl/ysyx_041461_div_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_041461_div_arbiter
//
// Purpose:
//   Shares one iterative divide unit between two requesters (0: EXE pipe,
//   1: secondary issue port). Arbitrates round-robin, registers the winning
//   operands, fires a one-cycle start pulse at the divider and waits for its
//   completion. The quotient/remainder are held for the owning requester
//   until consumed. A pipeline kill cancels an accepted, in-flight or pending
//   operation. A sticky watchdog flags a divider that never answers.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (2 bits)
//   req_signed/req_divw      per-requester operation flags (2 bits)
//   req_dividend/req_divisor packed operands, requester i in [i*XLEN +: XLEN]
//   resp_valid/resp_ready    per-requester result handshake (one-hot valid)
//   resp_quotient/remainder  held result, meaningful while resp_valid != 0
//   kill                     flush of the current operation
//   div_valid_in             start pulse to the divider
//   div_signed/div_divw      registered operation flags to the divider
//   div_dividend/div_divisor registered operands to the divider
//   div_valid_out            one-cycle divider completion
//   div_quotient/remainder   divider result, sampled on div_valid_out
//   err_timeout              sticky watchdog flag
// ---------------------------------------------------------------------------
module ysyx_041461_div_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_signed,
  input  logic [1:0]        req_divw,
  input  logic [2*XLEN-1:0] req_dividend,
  input  logic [2*XLEN-1:0] req_divisor,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [XLEN-1:0]   resp_quotient,
  output logic [XLEN-1:0]   resp_remainder,
  input  logic              kill,
  output logic              div_valid_in,
  output logic              div_signed,
  output logic              div_divw,
  output logic [XLEN-1:0]   div_dividend,
  output logic [XLEN-1:0]   div_divisor,
  input  logic              div_valid_out,
  input  logic [XLEN-1:0]   div_quotient,
  input  logic [XLEN-1:0]   div_remainder,
  output logic              err_timeout
);

  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t            state_reg, state_next;
  logic              rr_ptr_reg;
  logic              owner_reg;
  logic              signed_reg;
  logic              divw_reg;
  logic [XLEN-1:0]   dividend_reg;
  logic [XLEN-1:0]   divisor_reg;
  logic [XLEN-1:0]   quotient_reg;
  logic [XLEN-1:0]   remainder_reg;
  logic [WW-1:0]     wdog_reg;
  logic              err_reg;

  logic              grant;
  logic              accept;
  logic              waiting;
  logic              waiting_next;

  // Per-requester views of the packed operand buses
  logic [XLEN-1:0]   dividend_arr [2];
  logic [XLEN-1:0]   divisor_arr  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign dividend_arr[gi] = req_dividend[gi*XLEN +: XLEN];
      assign divisor_arr[gi]  = req_divisor[gi*XLEN +: XLEN];
    end
  endgenerate

  // A lone requester wins outright; on contention the round-robin pointer
  // decides. With no requester the grant is irrelevant (accept stays low).
  always_comb begin
    unique case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = rr_ptr_reg;
    endcase
  end

  assign accept       = (state_reg == S_IDLE) && req_valid[grant] && !kill;
  assign waiting      = (state_reg == S_BUSY) || (state_reg == S_DRAIN);
  assign waiting_next = (state_next == S_BUSY) || (state_next == S_DRAIN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        state_next = kill ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        // A kill coinciding with completion just drops the result; a kill
        // before completion must still absorb the divider's late answer.
        if (div_valid_out) state_next = kill ? S_IDLE : S_RESP;
        else if (kill)     state_next = S_DRAIN;
      end
      S_RESP: begin
        if (kill || resp_ready[owner_reg]) state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (div_valid_out) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready    = 2'b00;
    resp_valid   = 2'b00;
    div_valid_in = 1'b0;
    if (state_reg == S_IDLE && !kill && req_valid[grant]) begin
      req_ready[grant] = 1'b1;
    end
    if (state_reg == S_RESP) begin
      resp_valid[owner_reg] = 1'b1;
    end
    if (state_reg == S_ISSUE && !kill) begin
      div_valid_in = 1'b1;
    end
  end

  assign div_signed     = signed_reg;
  assign div_divw       = divw_reg;
  assign div_dividend   = dividend_reg;
  assign div_divisor    = divisor_reg;
  assign resp_quotient  = quotient_reg;
  assign resp_remainder = remainder_reg;
  assign err_timeout    = err_reg;

  // Operand, ownership and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= 1'b0;
      owner_reg     <= 1'b0;
      signed_reg    <= 1'b0;
      divw_reg      <= 1'b0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      if (accept) begin
        owner_reg    <= grant;
        rr_ptr_reg   <= ~grant;
        signed_reg   <= req_signed[grant];
        divw_reg     <= req_divw[grant];
        dividend_reg <= dividend_arr[grant];
        divisor_reg  <= divisor_arr[grant];
      end
      if (state_reg == S_BUSY && div_valid_out && !kill) begin
        quotient_reg  <= div_quotient;
        remainder_reg <= div_remainder;
      end
    end
  end

  // Watchdog: counts consecutive BUSY/DRAIN cycles. The counter saturates at
  // the trip value so it can never wrap back below it while still waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (waiting && waiting_next) begin
        if (wdog_reg != WW'(TIMEOUT - 1)) wdog_reg <= wdog_reg + 1'b1;
      end else begin
        wdog_reg <= '0;
      end
      if (waiting && !div_valid_out && wdog_reg == WW'(TIMEOUT - 1)) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_041461_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_041461_div_arbiter
//
// Drives the arbiter against a behavioural divider that answers a fixed
// number of cycles after each start pulse. Expected grants follow the
// round-robin rule, expected results come from a plain-arithmetic model of
// RISC-V DIV/DIVU/DIVW/DIVUW, and expected handshakes follow the cycle
// timeline of each operation (accept, issue, wait, respond, idle).
// ---------------------------------------------------------------------------
module tb_ysyx_041461_div_arbiter;

  localparam int XLEN    = 64;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_signed;
  logic [1:0]        req_divw;
  logic [2*XLEN-1:0] req_dividend;
  logic [2*XLEN-1:0] req_divisor;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [XLEN-1:0]   resp_quotient;
  logic [XLEN-1:0]   resp_remainder;
  logic              kill;
  logic              div_valid_in;
  logic              div_signed;
  logic              div_divw;
  logic [XLEN-1:0]   div_dividend;
  logic [XLEN-1:0]   div_divisor;
  logic              div_valid_out = 1'b0;
  logic [XLEN-1:0]   div_quotient  = '0;
  logic [XLEN-1:0]   div_remainder = '0;
  logic              err_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_rr   = 0;
  int pulses   = 0;
  int div_lat  = 1;
  bit div_hang = 1'b0;

  // divider model state
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [63:0] pend_q, pend_r;

  always #5 clk = ~clk;

  ysyx_041461_div_arbiter #(
    .XLEN   (XLEN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_signed    (req_signed),
    .req_divw      (req_divw),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_quotient (resp_quotient),
    .resp_remainder(resp_remainder),
    .kill          (kill),
    .div_valid_in  (div_valid_in),
    .div_signed    (div_signed),
    .div_divw      (div_divw),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_valid_out (div_valid_out),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .err_timeout   (err_timeout)
  );

  // RISC-V division semantics (W forms sign-extend their 32-bit result)
  function automatic void ref_div(input logic sg, input logic w,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    int          sa, sb;
    longint      la, lb;
    a32 = a[31:0];
    b32 = b[31:0];
    q32 = '0;
    r32 = '0;
    q   = '0;
    r   = '0;
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32;
      end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hffff_ffff) begin
        q32 = a32; r32 = '0;
      end else if (sg) begin
        sa = a32; sb = b32;
        q32 = 32'(sa / sb); r32 = 32'(sa % sb);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hffff_ffff_ffff_ffff) begin
        q = a; r = '0;
      end else if (sg) begin
        la = a; lb = b;
        q = 64'(la / lb); r = 64'(la % lb);
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  // Behavioural divider: answers div_lat cycles after the start pulse and
  // drives junk on its result bus at all other times.
  always @(negedge clk) begin
    div_valid_out = 1'b0;
    div_quotient  = {$urandom, $urandom};
    div_remainder = {$urandom, $urandom};
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          div_valid_out = 1'b1;
          div_quotient  = pend_q;
          div_remainder = pend_r;
          pend          = 1'b0;
        end
      end
      if (div_valid_in) begin
        pulses++;
        if (!div_hang) begin
          pend     = 1'b1;
          pend_cnt = div_lat;
          ref_div(div_signed, div_divw, div_dividend, div_divisor, pend_q, pend_r);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'($urandom_range(0, 50));
      1:       v = {$urandom, $urandom};
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'hffff_ffff_ffff_ffff;
      4:       v = 64'h0000_0000_8000_0000;
      default: v = {32'h0, $urandom};
    endcase
    return v;
  endfunction

  // Junk on the request side while the arbiter is not in IDLE
  task automatic scramble();
    req_valid    = 2'($urandom_range(1, 3));
    req_signed   = 2'($urandom_range(0, 3));
    req_divw     = 2'($urandom_range(0, 3));
    req_dividend = {$urandom, $urandom, $urandom, $urandom};
    req_divisor  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00; kill = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_val("rst_req_ready", req_ready, 2'b00);
    check_val("rst_resp_valid", resp_valid, 2'b00);
    check_val("rst_div_valid_in", div_valid_in, 1'b0);
    check_val("rst_div_dividend", div_dividend, 64'd0);
    check_val("rst_div_divisor", div_divisor, 64'd0);
    check_val("rst_div_flags", {div_signed, div_divw}, 2'b00);
    check_val("rst_resp_q", resp_quotient, 64'd0);
    check_val("rst_resp_r", resp_remainder, 64'd0);
    check_val("rst_err", err_timeout, 1'b0);
    exp_rr = 0;
  endtask

  // One operation from accept to the idle cycle afterwards.
  // kmode: 0 none, 1 kill in ISSUE, 2 kill in BUSY cycle kat (1..lat),
  //        3 kill in RESP cycle kat (0..hold)
  task automatic run_op(input logic [1:0] vpat, input logic [1:0] sg, input logic [1:0] dw,
                        input logic [63:0] a0, input logic [63:0] b0,
                        input logic [63:0] a1, input logic [63:0] b1,
                        input int lat, input int hold, input int kmode, input int kat,
                        output int gnt_obs, output logic [63:0] q_obs, output logic [63:0] r_obs);
    int          g, p0;
    logic [1:0]  g_oh, rdy;
    logic [63:0] ea, eb, eq, er;
    logic        es, ew;
    bit          drain_kill;
    q_obs = '0;
    r_obs = '0;
    g     = (vpat == 2'b01) ? 0 : (vpat == 2'b10) ? 1 : exp_rr;
    g_oh  = (g == 1) ? 2'b10 : 2'b01;
    ea    = (g == 1) ? a1 : a0;
    eb    = (g == 1) ? b1 : b0;
    es    = sg[g];
    ew    = dw[g];
    ref_div(es, ew, ea, eb, eq, er);
    drain_kill = 1'($urandom_range(0, 1));
    div_lat    = lat;
    p0         = pulses;

    // accept cycle
    tick();
    req_valid = vpat; req_signed = sg; req_divw = dw;
    req_dividend = {a1, a0}; req_divisor = {b1, b0};
    kill = 1'b0; resp_ready = 2'($urandom_range(0, 3));
    #1;
    check_val("accept_ready", req_ready, g_oh);
    check_val("accept_resp_valid", resp_valid, 2'b00);
    gnt_obs = (req_ready == 2'b10) ? 1 : (req_ready == 2'b01) ? 0 : -1;
    exp_rr  = 1 - g;

    // issue cycle
    tick();
    scramble();
    kill = (kmode == 1);
    #1;
    check_val("issue_ready", req_ready, 2'b00);
    check_val("issue_pulse", div_valid_in, (kmode == 1) ? 1'b0 : 1'b1);
    check_val("issue_dividend", div_dividend, ea);
    check_val("issue_divisor", div_divisor, eb);
    check_val("issue_flags", {div_signed, div_divw}, {es, ew});

    if (kmode != 1) begin
      for (int k = 1; k <= lat; k++) begin
        tick();
        scramble();
        resp_ready = 2'($urandom_range(0, 3));
        kill = (kmode == 2) && (k == kat || (k > kat && drain_kill));
        #1;
        check_val("busy_ready", req_ready, 2'b00);
        check_val("busy_pulse", div_valid_in, 1'b0);
        check_val("busy_resp_valid", resp_valid, 2'b00);
        check_val("busy_dividend", div_dividend, ea);
        check_val("busy_divisor", div_divisor, eb);
        check_val("busy_err", err_timeout, 1'b0);
      end
      if (kmode != 2) begin
        for (int j = 0; j <= hold; j++) begin
          tick();
          scramble();
          rdy    = 2'($urandom_range(0, 3));
          rdy[g] = (j == hold);
          resp_ready = rdy;
          kill = (kmode == 3) && (j == kat);
          #1;
          check_val("resp_valid", resp_valid, g_oh);
          check_val("resp_q", resp_quotient, eq);
          check_val("resp_r", resp_remainder, er);
          check_val("resp_ready_req", req_ready, 2'b00);
          q_obs = resp_quotient;
          r_obs = resp_remainder;
          if (kill) break;
        end
      end
    end

    // idle cycle
    tick();
    req_valid = 2'b00; resp_ready = 2'b00; kill = 1'b0;
    #1;
    check_val("idle_resp_valid", resp_valid, 2'b00);
    check_val("idle_req_ready", req_ready, 2'b00);
    check_val("idle_pulse", div_valid_in, 1'b0);
    check_val("pulse_count", 64'(pulses - p0), (kmode == 1) ? 64'd0 : 64'd1);
    $display("op vpat=%b grant=%0d s=%b w=%b a=%h b=%h lat=%0d hold=%0d kill_mode=%0d q=%h r=%h",
             vpat, gnt_obs, es, ew, ea, eb, lat, hold, kmode, eq, er);
  endtask

  initial begin
    int          g;
    logic [63:0] q, r;
    int          lat, hold, kmode, kat;

    rst = 1'b1; req_valid = 2'b00; req_signed = 2'b00; req_divw = 2'b00;
    req_dividend = '0; req_divisor = '0; resp_ready = 2'b00; kill = 1'b0;

    do_reset();

    // T1: requester 0 alone, 100/7 unsigned, divider answers 5 cycles later
    run_op(2'b01, 2'b00, 2'b00, 64'd100, 64'd7, rand_op(), rand_op(), 5, 0, 0, 0, g, q, r);
    check_val("t1_grant", 64'(g), 64'd0);
    check_val("t1_q", q, 64'd14);
    check_val("t1_r", r, 64'd2);

    // T2: both requesting every time, grants alternate starting from 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             rand_op(), rand_op(), rand_op(), rand_op(),
             $urandom_range(1, 6), 0, 0, 0, g, q, r);
      check_val("t2_grant", 64'(g), 64'(i % 2));
    end

    // T3: result held for 10 cycles without consumption
    run_op(2'b10, 2'b11, 2'b00, rand_op(), rand_op(), -64'sd77, 64'd5, 2, 10, 0, 0, g, q, r);
    check_val("t3_q", q, -64'sd15);
    check_val("t3_r", r, -64'sd2);

    // T4: kill in the first BUSY cycle, divider answers 3 cycles later
    run_op(2'b01, 2'b00, 2'b00, 64'd50, 64'd3, rand_op(), rand_op(), 4, 0, 2, 1, g, q, r);
    run_op(2'b01, 2'b00, 2'b00, 64'd50, 64'd3, rand_op(), rand_op(), 2, 0, 0, 0, g, q, r);
    check_val("t4_after_q", q, 64'd16);

    // T5: kill in ISSUE, start pulse must never appear
    run_op(2'b10, 2'b00, 2'b00, rand_op(), rand_op(), rand_op(), rand_op(), 3, 0, 1, 0, g, q, r);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      lat  = $urandom_range(1, 6);
      hold = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        6:       begin kmode = 1; kat = 0; end
        7, 8:    begin kmode = 2; kat = $urandom_range(1, lat); end
        9:       begin kmode = 3; kat = $urandom_range(0, hold); end
        default: begin kmode = 0; kat = 0; end
      endcase
      run_op(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             rand_op(), rand_op(), rand_op(), rand_op(), lat, hold, kmode, kat, g, q, r);
    end

    // T6: divider never answers, watchdog trips after TIMEOUT BUSY cycles
    do_reset();
    div_hang = 1'b1;
    tick();
    req_valid = 2'b01; req_dividend = {64'd9, 64'd81}; req_divisor = {64'd1, 64'd9};
    #1;
    check_val("t6_accept", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check_val("t6_pulse", div_valid_in, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      #1;
      check_val("t6_err", err_timeout, (k > TIMEOUT) ? 1'b1 : 1'b0);
      check_val("t6_resp_valid", resp_valid, 2'b00);
    end
    do_reset();
    div_hang = 1'b0;
    run_op(2'b11, 2'b00, 2'b00, 64'd81, 64'd9, rand_op(), rand_op(), 3, 1, 0, 0, g, q, r);
    check_val("t6_post_grant", 64'(g), 64'd0);
    check_val("t6_post_q", q, 64'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
